// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from an 8-deep synchronous FIFO and sends each one
// as an asynchronous serial frame on tx. The frame is a start bit, then WIDTH
// data bits LSB first, then STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT
// clocks.
//
// All outputs are registered. Each output register is loaded from the value
// the output must have in the *next* state. Because of this, the pins change
// on the same edge as the state register does, and never lag it by a cycle.

module fifo_uart_tx #(
  parameter int WIDTH        = 8,  // data bits per frame (matches FIFO word)
  parameter int CLKS_PER_BIT = 4,  // clk cycles per serial bit, >= 2
  parameter int STOP_BITS    = 1   // 1 or 2
) (
  input  logic             clk,
  input  logic             rst,          // synchronous, active-high
  input  logic             enable,       // allows new frames to start
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data, // valid the cycle after fifo_rd_en
  output logic             fifo_rd_en,   // one-cycle pop strobe per frame
  output logic             tx,           // serial line, idle high
  output logic             busy,         // FETCH through last STOP cycle
  output logic             done          // first IDLE cycle after STOP
);

  // Counter widths. They are clamped to 1 bit so that a degenerate
  // parameter value never produces a zero-width vector.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (WIDTH > 1)        ? $clog2(WIDTH)        : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,   // line idle; waiting for enable and a non-empty FIFO
    S_FETCH,  // pop strobe is high for this single cycle
    S_WAIT,   // FIFO read data is valid; captured on the exit edge
    S_START,  // start bit (line low)
    S_DATA,   // data bits, LSB first
    S_STOP    // stop bit(s) (line high)
  } state_e;

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;  // clocks within current bit
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;    // data bit index 0..WIDTH-1
  logic               stop_cnt_q, stop_cnt_d;  // stop bit index 0..STOP_BITS-1
  logic [WIDTH-1:0]   shift_q, shift_d;        // bit 0 is the bit on the line

  logic               tx_q, tx_d;
  logic               rd_en_q, rd_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               bit_end;  // last clock of the current serial bit

  assign bit_end = (baud_cnt_q == BAUD_LAST);

  // Next-state logic: sequences the frame and advances the counters.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves one unassigned would otherwise infer a latch.
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;

    case (state_q)
      S_IDLE: begin
        // fifo_empty is looked at only here. Later changes cannot cancel a
        // pop that has already been committed.
        if (enable && !fifo_empty) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        shift_d    = fifo_rd_data;
        baud_cnt_d = '0;
        state_d    = S_START;
      end

      S_START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (stop_cnt_q == STOP_LAST) begin
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output look-ahead: each registered output takes its next-state value.
  always_comb begin
    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State, counter, shift and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is a plain register rather than a memory.
      // It is cleared here together with the rest of the state, so no stale
      // data survives a reset.
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so that every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed plus randomized bench for fifo_uart_tx.
// A queue stands in for the FIFO. The expected line level for every clock
// of a frame is computed from the frame format with plain arithmetic.

module tb_fifo_uart_tx;

  localparam int W     = 8;
  localparam int C     = 4;
  localparam int SB    = 1;
  localparam int FRAME = (1 + W + SB) * C;
  localparam int NONE  = -99;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_rd_data = '0;
  logic         fifo_rd_en;
  logic         tx;
  logic         busy;
  logic         done;

  int n_assert = 0;
  int n_fail   = 0;

  // FIFO model state.
  logic [W-1:0] fifo_mem[$];
  int           pushes    = 0;
  int           pops      = 0;
  int           underflow = 0;
  int           n_rden    = 0;
  int           n_done    = 0;

  fifo_uart_tx #(
    .WIDTH       (W),
    .CLKS_PER_BIT(C),
    .STOP_BITS   (SB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (pushes == pops);

  // FIFO read port: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      if (fifo_mem.size() > 0) fifo_rd_data <= fifo_mem.pop_front();
      else                     underflow    <= underflow + 1;
      pops <= pops + 1;
    end
  end

  // Pulse counters, sampled at the edge on which the pulse is stable.
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) n_rden <= n_rden + 1;
    if (done === 1'b1)       n_done <= n_done + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_mem.push_back(w);
    pushes++;
  endtask

  // Line level at clock k of a frame, counted from the first start-bit clock.
  function automatic logic exp_bit(input logic [W-1:0] w, input int k);
    int b;
    b = k / C;
    if (b == 0)      return 1'b0;
    else if (b <= W) return w[b-1];
    else             return 1'b1;
  endfunction

  // Waits (bounded) until the pop strobe is visible; returns cycles waited.
  task automatic wait_fetch(input string tag, output int waited);
    waited = 0;
    while (fifo_rd_en !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_fetch"}, fifo_rd_en, 1);
  endtask

  // Checks one whole frame for word w. Returns at the done cycle.
  // drop_at: -1 lowers enable in FETCH; k >= 0 lowers it at frame clock k.
  task automatic send_frame(input logic [W-1:0] w, input string tag,
                            input int drop_at, output int waited);
    int           errs;
    logic [W-1:0] decoded;
    wait_fetch(tag, waited);
    errs    = 0;
    decoded = '0;
    if (tx !== 1'b1 || busy !== 1'b1) errs++;
    if (drop_at == -1) enable = 1'b0;
    @(negedge clk);  // WAIT
    if (tx !== 1'b1 || busy !== 1'b1 || fifo_rd_en !== 1'b0) errs++;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == drop_at) enable = 1'b0;
      if (tx !== exp_bit(w, k)) errs++;
      if (busy !== 1'b1 || done !== 1'b0 || fifo_rd_en !== 1'b0) errs++;
      if ((k % C) == (C / 2) && (k / C) >= 1 && (k / C) <= W) decoded[(k / C) - 1] = tx;
    end
    @(negedge clk);  // first IDLE cycle
    check({tag, "_bits"}, errs, 0);
    check({tag, "_word"}, decoded, w);
    check({tag, "_done"}, {done, busy, tx}, 3'b101);
  endtask

  initial begin
    int           waited;
    int           errs;
    int           base_rd;
    int           base_dn;
    logic [W-1:0] rw[4];

    rst    = 1'b1;
    enable = 1'b1;
    push(8'hA5);

    // 1: reset held 3 cycles with a non-empty FIFO and enable high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {tx, fifo_rd_en, busy, done}, 4'b1000);
    end
    rst = 1'b0;

    // 2: single word 0xA5.
    send_frame(8'hA5, "single", NONE, waited);
    @(negedge clk);
    check("single_rden_count", n_rden, 1);
    check("single_done_count", n_done, 1);

    // 3: back-to-back 0x00, 0xFF, 0x3C.
    base_rd = n_rden;
    push(8'h00); push(8'hFF); push(8'h3C);
    send_frame(8'h00, "b2b0", NONE, waited);
    send_frame(8'hFF, "b2b1", NONE, waited);
    check("b2b1_gap", waited, 1);
    send_frame(8'h3C, "b2b2", NONE, waited);
    check("b2b2_gap", waited, 1);
    @(negedge clk);
    check("b2b_rden_count", n_rden - base_rd, 3);

    // Randomized back-to-back burst.
    for (int i = 0; i < 4; i++) begin
      rw[i] = W'($urandom);
      push(rw[i]);
    end
    for (int i = 0; i < 4; i++) begin
      send_frame(rw[i], $sformatf("rand%0d", i), NONE, waited);
      if (i > 0) check($sformatf("rand%0d_gap", i), waited, 1);
    end

    // 4: empty FIFO with enable high for 100 cycles, then one word arrives.
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("empty_idle", errs, 0);
    rw[0] = W'($urandom);
    push(rw[0]);
    @(negedge clk);
    check("empty_release_fetch", fifo_rd_en, 1);
    send_frame(rw[0], "empty_release", NONE, waited);
    @(negedge clk);

    // 5: reset during data bit 3 of 0x5A; next queued word follows.
    base_rd = n_rden;
    base_dn = n_done;
    push(8'h5A); push(8'h96);
    wait_fetch("rst_mid", waited);
    for (int i = 1; i <= 19; i++) @(negedge clk);
    check("rst_mid_before", {busy, tx}, {1'b1, exp_bit(8'h5A, 17)});
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_after", {tx, busy, done, fifo_rd_en}, 4'b1000);
    rst = 1'b0;
    send_frame(8'h96, "rst_next", NONE, waited);
    @(negedge clk);
    check("rst_rden_count", n_rden - base_rd, 2);
    check("rst_done_count", n_done - base_dn, 1);
    check("rst_fifo_drained", fifo_empty, 1);

    // 6: enable lowered mid-START of 0xC3 while the FIFO is still non-empty.
    push(8'hC3); push(8'h77);
    send_frame(8'hC3, "en_drop_start", 2, waited);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("en_drop_hold", errs, 0);
    check("en_drop_fifo_kept", fifo_empty, 0);
    enable = 1'b1;
    send_frame(8'h77, "en_return", NONE, waited);
    check("en_return_gap", waited, 1);

    // 7: enable lowered during FETCH: the popped word is still sent.
    rw[1] = W'($urandom);
    rw[2] = W'($urandom);
    push(rw[1]); push(rw[2]);
    send_frame(rw[1], "en_drop_fetch", -1, waited);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0) errs++;
    end
    check("en_fetch_hold", errs, 0);
    enable = 1'b1;
    send_frame(rw[2], "en_fetch_next", NONE, waited);
    @(negedge clk);

    check("no_underflow", underflow, 0);
    check("pops_match_pushes", pops, pushes);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
